// File: rtl/spi_usb_responder.sv
// spi_usb_responder
//   SPI mode-0 peripheral that stands in for the USB host-controller shield in
//   simulation and loopback builds. It holds a 32x8 register file that is reached
//   through a MAX3421E-style command byte, formatted as {addr[4:0], x, dir, x}.
//   It also holds an IRQ flag register and an IRQ enable register, and drives an
//   active-low irq output. The SPI pins are oversampled by Clk.
//
// Ports
//   Clk      in   system clock (SCLK must be at most Clk/8)
//   Reset_n  in   asynchronous reset, active low
//   sclk     in   SPI clock, idle low
//   ss_n     in   SPI select, active low
//   mosi     in   SPI data in, MSB first
//   miso     out  SPI data out, MSB first
//   miso_oe  out  high while selected; the top level tristates miso when low
//   irq_n    out  low when any enabled flag is set
//   irq_set  in   one-cycle mask ORed into the flag register
//   rd_addr  in   local read address
//   rd_data  out  reg[rd_addr], combinational
//   wr_stb   out  one-cycle pulse per completed SPI write byte
//   wr_addr  out  address of that write
//   wr_data  out  data of that write
//
// state | meaning
// IDLE  | deselected, miso_oe low, waiting for ss_n to fall
// CMD   | shifting in the command byte, shifting out the status byte
// DATA  | data bytes: write (dir=1) or read, address auto-advances
module spi_usb_responder #(
    parameter int         IRQ_ADDR = 25,
    parameter int         IEN_ADDR = 26,
    parameter int         AUTO_INC = 1,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       irq_n,
    input  logic [7:0] irq_set,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [4:0] IRQ_A = 5'(IRQ_ADDR);
    localparam logic [4:0] IEN_A = 5'(IEN_ADDR);

    logic [7:0] regs [32];

    logic [1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d;
    logic       sclk_s, ss_s, mosi_s;
    logic       rise, fall;

    logic [1:0] state;
    logic [2:0] bitcnt;
    logic [7:0] rx, tx;
    logic [7:0] rx_next;
    logic [4:0] addr;
    logic       dir;
    logic       spi_wr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ss_sync   <= {ss_sync[0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign sclk_s  = sclk_sync[1];
    assign ss_s    = ss_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign rx_next = {rx[6:0], mosi_s};

    // Completed data byte of a write transfer; the register file commits it on this edge.
    assign spi_wr = (state == DATA) && !ss_s && rise && (bitcnt == 3'd7) && dir;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            bitcnt  <= 3'd0;
            rx      <= 8'h00;
            tx      <= 8'h00;
            addr    <= 5'd0;
            dir     <= 1'b0;
            miso_oe <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (ss_s) begin
                // Deselect at any time discards a partial byte.
                state   <= IDLE;
                bitcnt  <= 3'd0;
                tx      <= 8'h00;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bitcnt  <= 3'd0;
                        tx      <= regs[IRQ_A];
                        miso_oe <= 1'b1;
                    end
                    CMD, DATA: begin
                        if (rise) begin
                            rx     <= rx_next;
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                if (state == CMD) begin
                                    addr  <= rx_next[7:3];
                                    dir   <= rx_next[1];
                                    state <= DATA;
                                end else begin
                                    if (dir) begin
                                        wr_stb  <= 1'b1;
                                        wr_addr <= addr;
                                        wr_data <= rx_next;
                                    end
                                    if (AUTO_INC != 0)
                                        addr <= addr + 5'd1;
                                end
                            end
                        end else if (fall) begin
                            // bitcnt wraps to 0 only after the 8th rise, so this is the 8th fall.
                            if (bitcnt == 3'd0)
                                tx <= regs[addr];
                            else
                                tx <= {tx[6:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Flag register: a W1C write and irq_set can land in the same cycle; set wins per bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= RST_VAL;
        end else begin
            if (spi_wr && (addr != IRQ_A))
                regs[addr] <= rx_next;
            if (spi_wr && (addr == IRQ_A))
                regs[IRQ_A] <= (regs[IRQ_A] & ~rx_next) | irq_set;
            else
                regs[IRQ_A] <= regs[IRQ_A] | irq_set;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            irq_n <= 1'b1;
        else
            irq_n <= ~|(regs[IRQ_A] & regs[IEN_A]);
    end

    assign miso    = tx[7];
    assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_spi_usb_responder.sv
module tb_spi_usb_responder;

    localparam int H = 8;  // SCLK half period in Clk cycles

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic [7:0] irq_set = 8'h00;
    logic [4:0] rd_addr = 5'd0;

    logic       miso, miso_oe, irq_n, wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] rd_data, wr_data;

    logic       miso0, miso_oe0, irq_n0, wr_stb0;
    logic [4:0] wr_addr0;
    logic [7:0] rd_data0, wr_data0;

    int n_vec = 0;
    int n_fail = 0;

    always #10 Clk = ~Clk;

    spi_usb_responder dut (
        .Clk(Clk), .Reset_n(Reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .irq_n(irq_n), .irq_set(irq_set),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    spi_usb_responder #(.AUTO_INC(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .irq_n(irq_n0), .irq_set(irq_set),
        .rd_addr(rd_addr), .rd_data(rd_data0), .wr_stb(wr_stb0),
        .wr_addr(wr_addr0), .wr_data(wr_data0)
    );

    logic [4:0] stb_a[$];
    logic [7:0] stb_d[$];
    logic [4:0] stb0_a[$];

    always @(negedge Clk) begin
        if (wr_stb) begin
            stb_a.push_back(wr_addr);
            stb_d.push_back(wr_data);
        end
        if (wr_stb0)
            stb0_a.push_back(wr_addr0);
    end

    typedef struct {
        int         n;
        logic [7:0] mo [8];
        logic [7:0] mi [8];
        int         stb;
        logic [4:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; irq_set = 8'h00;
        clks(3);
        Reset_n = 1'b1;
        clks(3);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = b[7-i];
            clks(H);
            r[7-i] = miso;
            sclk = 1'b1;
            clks(H);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input int n, input logic [7:0] mo [8], output logic [7:0] mi [8]);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) mi[i] = 8'h00;
        ss_n = 1'b0;
        clks(H);
        for (int i = 0; i < n; i++) begin
            spi_bits(mo[i], 8, r);
            mi[i] = r;
        end
        clks(H);
        ss_n = 1'b1;
        clks(H);
    endtask

    task automatic xfer2(input logic [7:0] a, input logic [7:0] b, output logic [7:0] status);
        logic [7:0] mo [8];
        logic [7:0] mi [8];
        for (int i = 0; i < 8; i++) mo[i] = 8'h00;
        mo[0] = a; mo[1] = b;
        xfer(2, mo, mi);
        status = mi[0];
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(name, {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic set_vec(input int k, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                           input int stb, input logic [4:0] wa, input logic [7:0] wd);
        for (int i = 0; i < 8; i++) begin
            vecs[k].mo[i] = 8'h00;
            vecs[k].mi[i] = 8'h00;
        end
        vecs[k].n = n;
        vecs[k].mo[0] = b0; vecs[k].mo[1] = b1; vecs[k].mo[2] = b2; vecs[k].mo[3] = b3;
        vecs[k].mi[0] = e0; vecs[k].mi[1] = e1; vecs[k].mi[2] = e2; vecs[k].mi[3] = e3;
        vecs[k].stb = stb; vecs[k].wa = wa; vecs[k].wd = wd;
    endtask

    logic [7:0] m_regs [32];

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mo [8];
        logic [7:0] mi [8];
        logic [7:0] exp_mi [8];
        logic [4:0] ea[$];
        logic [7:0] ed[$];
        logic [7:0] st, r, v;
        int nd, a;
        logic drw;

        // ---- reset state ----
        do_reset();
        for (int i = 0; i < 32; i++) rd_chk("reset_reg", 5'(i), 8'h00);
        chk("reset_irq_n", {31'h0, irq_n}, 32'h1);
        chk("reset_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("reset_miso", {31'h0, miso}, 32'h0);

        // ---- directed table ----
        set_vec(0, 2, 8'h52, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 5'd10, 8'hA5);
        set_vec(1, 4, 8'hFA, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 3, 5'd1, 8'h33);
        set_vec(2, 4, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 0, 5'd0, 8'h00);
        set_vec(3, 2, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 5'd0, 8'h00);
        set_vec(4, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00, 0, 5'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            stb_a.delete(); stb_d.delete();
            mo = vecs[k].mo;
            xfer(vecs[k].n, mo, mi);
            for (int i = 0; i < vecs[k].n; i++)
                chk($sformatf("tbl%0d_miso%0d", k, i), {24'h0, mi[i]}, {24'h0, vecs[k].mi[i]});
            chk($sformatf("tbl%0d_stb_count", k), stb_a.size(), vecs[k].stb);
            if (vecs[k].stb > 0 && stb_a.size() > 0) begin
                chk($sformatf("tbl%0d_wr_addr", k), {27'h0, stb_a[$]}, {27'h0, vecs[k].wa});
                chk($sformatf("tbl%0d_wr_data", k), {24'h0, stb_d[$]}, {24'h0, vecs[k].wd});
            end
        end
        rd_chk("tbl_reg10", 5'd10, 8'hA5);
        rd_chk("tbl_reg31", 5'd31, 8'h11);
        rd_chk("tbl_reg0", 5'd0, 8'h22);
        rd_chk("tbl_reg1", 5'd1, 8'h33);

        // ---- randomized transfers against a transaction-level model ----
        do_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = 8'($urandom);
                irq_set = v;
                clks(1);
                irq_set = 8'h00;
                clks(2);
                m_regs[25] = m_regs[25] | v;
            end
            case ($urandom_range(0, 3))
                0: a = 25;
                1: a = 26;
                default: a = int'($urandom_range(0, 31));
            endcase
            drw = 1'($urandom);
            nd = int'($urandom_range(1, 4));
            mo[0] = {5'(a), 1'($urandom), drw, 1'($urandom)};
            for (int i = 1; i < 8; i++) mo[i] = 8'($urandom);

            ea.delete(); ed.delete();
            exp_mi[0] = m_regs[25];
            exp_mi[1] = m_regs[a];
            for (int k = 1; k <= nd; k++) begin
                if (drw) begin
                    m_regs[a] = (a == 25) ? (m_regs[a] & ~mo[k]) : mo[k];
                    ea.push_back(5'(a));
                    ed.push_back(mo[k]);
                end
                a = (a + 1) % 32;
                if (k < nd) exp_mi[k+1] = m_regs[a];
            end

            stb_a.delete(); stb_d.delete();
            xfer(nd + 1, mo, mi);
            for (int i = 0; i <= nd; i++)
                chk($sformatf("rnd%0d_miso%0d", t, i), {24'h0, mi[i]}, {24'h0, exp_mi[i]});
            chk($sformatf("rnd%0d_stb_count", t), stb_a.size(), ea.size());
            for (int i = 0; i < ea.size() && i < stb_a.size(); i++) begin
                chk($sformatf("rnd%0d_wa%0d", t, i), {27'h0, stb_a[i]}, {27'h0, ea[i]});
                chk($sformatf("rnd%0d_wd%0d", t, i), {24'h0, stb_d[i]}, {24'h0, ed[i]});
            end
        end
        for (int i = 0; i < 32; i++) rd_chk($sformatf("rnd_reg%0d", i), 5'(i), m_regs[i]);
        chk("rnd_irq_n", {31'h0, irq_n}, {31'h0, ~|(m_regs[25] & m_regs[26])});

        // ---- IRQ flags / enable / W1C vs set ----
        do_reset();
        irq_set = 8'h05; clks(1); irq_set = 8'h00; clks(2);
        rd_chk("irq_flag_set", 5'd25, 8'h05);
        chk("irq_n_disabled", {31'h0, irq_n}, 32'h1);
        xfer2(8'hD2, 8'h04, st);
        clks(3);
        chk("irq_n_enabled", {31'h0, irq_n}, 32'h0);
        irq_set = 8'h04;
        xfer2(8'hCA, 8'h04, st);
        irq_set = 8'h00;
        clks(3);
        chk("w1c_set_status", {24'h0, st}, 32'h05);
        rd_chk("w1c_set_wins", 5'd25, 8'h05);
        chk("w1c_set_irq_n", {31'h0, irq_n}, 32'h0);
        xfer2(8'hCA, 8'h04, st);
        clks(3);
        rd_chk("w1c_clear", 5'd25, 8'h01);
        chk("w1c_clear_irq_n", {31'h0, irq_n}, 32'h1);

        // ---- deselect mid-byte ----
        stb_a.delete(); stb_d.delete();
        ss_n = 1'b0;
        clks(H);
        chk("sel_miso_oe", {31'h0, miso_oe}, 32'h1);
        spi_bits(8'h62, 8, r);
        spi_bits(8'hFF, 5, r);
        clks(H);
        ss_n = 1'b1;
        clks(H);
        chk("abort_stb_count", stb_a.size(), 0);
        rd_chk("abort_reg12", 5'd12, 8'h00);
        chk("abort_miso_oe", {31'h0, miso_oe}, 32'h0);
        xfer2(8'h62, 8'h3C, st);
        chk("after_abort_stb", stb_a.size(), 1);
        if (stb_a.size() > 0) chk("after_abort_wa", {27'h0, stb_a[0]}, 32'd12);
        rd_chk("after_abort_reg12", 5'd12, 8'h3C);

        // ---- reset mid-burst ----
        irq_set = 8'h04; clks(1); irq_set = 8'h00; clks(3);
        chk("pre_rst_irq_n", {31'h0, irq_n}, 32'h0);
        rd_addr = 5'd12;
        ss_n = 1'b0;
        clks(H);
        spi_bits(8'h6A, 8, r);
        spi_bits(8'h55, 8, r);
        spi_bits(8'hF0, 3, r);
        Reset_n = 1'b0;
        #1;
        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_irq_n", {31'h0, irq_n}, 32'h1);
        chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        chk("rst_wr_addr", {27'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_reg12", {24'h0, rd_data}, 32'h0);
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        clks(3);
        Reset_n = 1'b1;
        clks(3);
        rd_chk("rst_reg13", 5'd13, 8'h00);
        rd_chk("rst_reg26", 5'd26, 8'h00);

        // ---- held address (AUTO_INC=0 instance) ----
        stb0_a.delete();
        for (int i = 0; i < 8; i++) mo[i] = 8'h00;
        mo[0] = 8'h42; mo[1] = 8'h01; mo[2] = 8'h02; mo[3] = 8'h03;
        xfer(4, mo, mi);
        chk("noinc_stb_count", stb0_a.size(), 3);
        for (int i = 0; i < stb0_a.size(); i++)
            chk($sformatf("noinc_wa%0d", i), {27'h0, stb0_a[i]}, 32'd8);
        rd_addr = 5'd8; #1;
        chk("noinc_reg8", {24'h0, rd_data0}, 32'h03);
        rd_addr = 5'd9; #1;
        chk("noinc_reg9", {24'h0, rd_data0}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
